// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds bus widths, common constants and the fetch FSM encoding.
package inst_fetch_pkg;

    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        RstEnable   = 1'b1;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;

    // Fetch FSM: BOOT keeps the ROM disabled for one cycle after reset,
    // RUN fetches every cycle, HOLD keeps the ROM enabled with a frozen PC.
    typedef enum logic [1:0] {
        IfBoot = 2'd0,
        IfRun  = 2'd1,
        IfHold = 2'd2
    } if_state_t;

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID boundary register.
// Flush zeroes it, stall_id holds it, stall_if inserts a bubble; otherwise
// it captures the current PC/ROM word. Misaligned PCs capture a zero word
// with the address-error flag set.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush, stall_if/id    pipeline control
//   pc, inst, ce          current fetch (PC, ROM word, ROM chip enable)
//   id_pc/inst/valid/adel registered outputs to decode
module if_id_reg
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic [ADDR_W-1:0] pc,
    input  logic [INST_W-1:0] inst,
    input  logic              ce,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_valid,
    output logic              id_adel
);

    logic misaligned;
    assign misaligned = |pc[1:0];

    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush) begin
            id_pc    <= '0;
            id_inst  <= '0;
            id_valid <= 1'b0;
            id_adel  <= 1'b0;
        end else if (stall_id) begin
            id_pc    <= id_pc;
            id_inst  <= id_inst;
            id_valid <= id_valid;
            id_adel  <= id_adel;
        end else if (stall_if) begin
            id_pc    <= '0;
            id_inst  <= '0;
            id_valid <= 1'b0;
            id_adel  <= 1'b0;
        end else begin
            id_pc    <= pc;
            id_valid <= ce;
            id_inst  <= misaligned ? '0 : inst;
            id_adel  <= misaligned;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: program counter, ROM interface, fetch FSM,
// IF/ID register and retired-fetch counter.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   stall_if, stall_id, flush      pipeline control
//   new_pc                         flush target
//   branch_flag_i, branch_target_address_i  branch redirect from ID
//   rom_ce_o, rom_addr_o, rom_inst_i        combinational ROM interface
//   id_pc_o, id_inst_o, id_valid_o, id_adel_o  IF/ID contents
//   fetch_cnt_o                    number of valid fetches accepted
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o,
    output logic              id_adel_o,
    output logic [31:0]       fetch_cnt_o
);

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    if_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [31:0]       fetch_cnt_reg;
    logic              fetch_accept;

    // State register and PC
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_reg <= IfBoot;
            pc_reg    <= PC_INIT;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // Next state, next PC and ROM enable
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        rom_ce_o   = ChipEnable;

        case (state_reg)
            IfBoot: begin
                rom_ce_o   = ChipDisable;
                state_next = IfRun;
            end
            IfRun: begin
                if (stall_if && !flush) state_next = IfHold;
            end
            IfHold: begin
                if (!stall_if || flush) state_next = IfRun;
            end
            default: begin
                state_next = IfBoot;
            end
        endcase

        // A branch seen while stalled is dropped; ID re-presents it.
        if (flush) begin
            pc_next = new_pc;
        end else if (stall_if || state_reg == IfBoot) begin
            pc_next = pc_reg;
        end else if (branch_flag_i) begin
            pc_next = branch_target_address_i;
        end else begin
            pc_next = pc_reg + ADDR_W'(4);
        end
    end

    assign rom_addr_o = pc_reg;

    if_id_reg #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .stall_if (stall_if),
        .stall_id (stall_id),
        .pc       (pc_reg),
        .inst     (rom_inst_i),
        .ce       (rom_ce_o),
        .id_pc    (id_pc_o),
        .id_inst  (id_inst_o),
        .id_valid (id_valid_o),
        .id_adel  (id_adel_o)
    );

    // Counts exactly the captures that load a valid fetch into IF/ID.
    assign fetch_accept = !flush && !stall_id && !stall_if && rom_ce_o;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            fetch_cnt_reg <= '0;
        end else if (fetch_accept) begin
            fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch. The ROM model returns word = address.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_if = 1'b0;
    logic        stall_id = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = '0;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        id_adel_o;
    logic [31:0] fetch_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign rom_inst_i = rom_ce_o ? rom_addr_o : 32'h0;

    inst_fetch dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall_if                (stall_if),
        .stall_id                (stall_id),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .rom_ce_o                (rom_ce_o),
        .rom_addr_o              (rom_addr_o),
        .rom_inst_i              (rom_inst_i),
        .id_pc_o                 (id_pc_o),
        .id_inst_o               (id_inst_o),
        .id_valid_o              (id_valid_o),
        .id_adel_o               (id_adel_o),
        .fetch_cnt_o             (fetch_cnt_o)
    );

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset for one cycle, release, and take the BOOT edge: PC = 0, RUN.
    task automatic restart();
        rst = 1'b1;
        stall_if = 0; stall_id = 0; flush = 0; branch_flag_i = 0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0 || id_pc_o !== 32'h0 ||
            id_inst_o !== 32'h0 || id_valid_o !== 1'b0 || id_adel_o !== 1'b0 ||
            fetch_cnt_o !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: ce=%b addr=%h pc=%h inst=%h v=%b adel=%b cnt=%0d required all zero",
                     rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o, fetch_cnt_o);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (rom_ce_o !== 1'b0) begin
            n_bad++; $display("FAIL boot_ce: got %b required 0", rom_ce_o);
        end
        step();  // edge 1 after release
        n_cmp++;
        if (rom_ce_o !== 1'b1 || id_valid_o !== 1'b0 || rom_addr_o !== 32'h0) begin
            n_bad++;
            $display("FAIL release_edge1: ce=%b v=%b addr=%h required ce=1 v=0 addr=0", rom_ce_o, id_valid_o, rom_addr_o);
        end
        step();  // edge 2
        n_cmp++;
        if (id_pc_o !== 32'h0 || id_valid_o !== 1'b1 || id_inst_o !== 32'h0 || rom_addr_o !== 32'h4) begin
            n_bad++;
            $display("FAIL release_edge2: pc=%h v=%b inst=%h addr=%h required pc=0 v=1 inst=0 addr=4",
                     id_pc_o, id_valid_o, id_inst_o, rom_addr_o);
        end
        step();  // edge 3
        n_cmp++;
        if (id_pc_o !== 32'h4 || id_inst_o !== 32'h4 || id_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL release_edge3: pc=%h inst=%h v=%b required pc=4 inst=4 v=1", id_pc_o, id_inst_o, id_valid_o);
        end
        repeat (3) step();  // edge 6
        n_cmp++;
        if (fetch_cnt_o !== 32'd5) begin
            n_bad++; $display("FAIL release_count: got %0d required 5", fetch_cnt_o);
        end
        $display("test_reset done: cnt=%0d", fetch_cnt_o);
    endtask

    task automatic test_branch();
        restart();
        repeat (2) step();  // PC = 0x8
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h100;
        step();
        branch_flag_i = 1'b0;
        n_cmp++;
        if (id_pc_o !== 32'h8 || id_inst_o !== 32'h8 || rom_addr_o !== 32'h100) begin
            n_bad++;
            $display("FAIL branch_delay_slot: pc=%h inst=%h addr=%h required pc=8 inst=8 addr=100",
                     id_pc_o, id_inst_o, rom_addr_o);
        end
        step();
        n_cmp++;
        if (id_pc_o !== 32'h100 || id_inst_o !== 32'h100 || rom_addr_o !== 32'h104) begin
            n_bad++;
            $display("FAIL branch_target: pc=%h inst=%h addr=%h required pc=100 inst=100 addr=104",
                     id_pc_o, id_inst_o, rom_addr_o);
        end
        $display("test_branch done: id_pc=%h", id_pc_o);
    endtask

    task automatic test_stall();
        restart();
        repeat (4) step();  // PC = 0x10, IF/ID = 0xC, cnt = 4
        stall_if = 1'b1;
        stall_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (rom_addr_o !== 32'h10 || id_pc_o !== 32'hC || id_inst_o !== 32'hC ||
                id_valid_o !== 1'b1 || fetch_cnt_o !== 32'd4 || rom_ce_o !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: addr=%h pc=%h inst=%h v=%b cnt=%0d ce=%b required addr=10 pc=c inst=c v=1 cnt=4 ce=1",
                         i, rom_addr_o, id_pc_o, id_inst_o, id_valid_o, fetch_cnt_o, rom_ce_o);
            end
        end
        stall_if = 1'b0;
        stall_id = 1'b0;
        step();
        n_cmp++;
        if (id_pc_o !== 32'h10 || fetch_cnt_o !== 32'd5 || rom_addr_o !== 32'h14) begin
            n_bad++;
            $display("FAIL stall_release1: pc=%h cnt=%0d addr=%h required pc=10 cnt=5 addr=14", id_pc_o, fetch_cnt_o, rom_addr_o);
        end
        step();
        n_cmp++;
        if (id_pc_o !== 32'h14 || fetch_cnt_o !== 32'd6) begin
            n_bad++;
            $display("FAIL stall_release2: pc=%h cnt=%0d required pc=14 cnt=6", id_pc_o, fetch_cnt_o);
        end
        $display("test_stall done: cnt=%0d", fetch_cnt_o);
    endtask

    task automatic test_flush();
        restart();
        step();  // PC = 0x4
        flush = 1'b1; new_pc = 32'h20;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h300;
        stall_if = 1'b1;
        step();
        flush = 1'b0; branch_flag_i = 1'b0; stall_if = 1'b0;
        n_cmp++;
        if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_inst_o !== 32'h0 ||
            rom_addr_o !== 32'h20 || dut.state_reg !== IfRun) begin
            n_bad++;
            $display("FAIL flush_priority: v=%b pc=%h inst=%h addr=%h state=%0d required v=0 pc=0 inst=0 addr=20 state=RUN",
                     id_valid_o, id_pc_o, id_inst_o, rom_addr_o, dut.state_reg);
        end
        step();
        n_cmp++;
        if (id_pc_o !== 32'h20 || id_inst_o !== 32'h20 || id_valid_o !== 1'b1 || rom_addr_o !== 32'h24) begin
            n_bad++;
            $display("FAIL flush_target: pc=%h inst=%h v=%b addr=%h required pc=20 inst=20 v=1 addr=24",
                     id_pc_o, id_inst_o, id_valid_o, rom_addr_o);
        end
        $display("test_flush done: addr=%h", rom_addr_o);
    endtask

    task automatic test_misaligned();
        flush = 1'b1; new_pc = 32'h202;
        step();
        flush = 1'b0;
        n_cmp++;
        if (rom_addr_o !== 32'h202 || id_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL misalign_redirect: addr=%h v=%b required addr=202 v=0", rom_addr_o, id_valid_o);
        end
        step();
        n_cmp++;
        if (id_pc_o !== 32'h202 || id_inst_o !== 32'h0 || id_adel_o !== 1'b1 ||
            id_valid_o !== 1'b1 || rom_addr_o !== 32'h206) begin
            n_bad++;
            $display("FAIL misalign_capture: pc=%h inst=%h adel=%b v=%b addr=%h required pc=202 inst=0 adel=1 v=1 addr=206",
                     id_pc_o, id_inst_o, id_adel_o, id_valid_o, rom_addr_o);
        end
        step();
        n_cmp++;
        if (id_pc_o !== 32'h206 || id_adel_o !== 1'b1 || id_inst_o !== 32'h0) begin
            n_bad++;
            $display("FAIL misalign_next: pc=%h adel=%b inst=%h required pc=206 adel=1 inst=0", id_pc_o, id_adel_o, id_inst_o);
        end
        $display("test_misaligned done: id_pc=%h", id_pc_o);
    endtask

    task automatic test_midrun_reset();
        flush = 1'b1; new_pc = 32'h40;
        step();
        flush = 1'b0;
        step();  // IF/ID = 0x40, PC = 0x44
        flush = 1'b1; new_pc = 32'h40;  // back to PC = 0x40 with IF/ID holding data
        step();
        flush = 1'b0;
        step();  // IF/ID = 0x40 valid, PC = 0x44
        rst = 1'b1;
        stall_if = 1'b1;
        step();
        n_cmp++;
        if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0 || id_pc_o !== 32'h0 ||
            id_inst_o !== 32'h0 || id_valid_o !== 1'b0 || id_adel_o !== 1'b0 ||
            fetch_cnt_o !== 32'h0) begin
            n_bad++;
            $display("FAIL midrun_reset: ce=%b addr=%h pc=%h inst=%h v=%b adel=%b cnt=%0d required all zero",
                     rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o, fetch_cnt_o);
        end
        rst = 1'b0;
        stall_if = 1'b0;
        $display("test_midrun_reset done: cnt=%0d", fetch_cnt_o);
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall();
        test_flush();
        test_misaligned();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
